run_sequencer: RTL
==================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles core_reset is held high.
REQ-002 Parameter N_CHECK, default 4: number of result words read back, addresses 0..N_CHECK-1 (range 1..256).
REQ-003 Parameter TIMEOUT, default 1000: maximum RUN cycles before abort (range 1..65535).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 core_reset  out  1  reset to the processor under control.
REQ-008 core_done  in  1  processor completion flag, level.
REQ-009 rd_addr  out  8  result-memory read address.
REQ-010 rd_data  in  8  result-memory read data, valid one cycle after rd_addr is presented.
REQ-011 exp_data  in  8  expected value for the current rd_addr, combinational from an external table, valid in the same cycle as rd_data.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 finished  out  1  high while in DONE.
REQ-014 pass  out  1  high in DONE when all N_CHECK words matched and no timeout occurred.
REQ-015 timeout  out  1  high in DONE when the run was aborted by TIMEOUT.
REQ-016 fail_addr  out  8  address of the first mismatch; 0 when none.
REQ-017 cycle_count  out  16  number of RUN cycles of the last run.

Function
REQ-018 The block SHALL implement states IDLE, CRST, RUN, ISSUE, CHECK, DONE.
REQ-019 IDLE: on start=1, SHALL clear pass, timeout, fail_addr, and cycle_count, and go to CRST.
REQ-020 CRST: core_reset SHALL be 1 for exactly RST_CYCLES consecutive cycles, then the block SHALL go to RUN; core_reset SHALL be 0 in all other states.
REQ-021 RUN: cycle_count SHALL increment by 1 each cycle, saturating at 0xFFFF.
REQ-022 RUN: if core_done=1, the block SHALL go to ISSUE with the word index at 0; core_done SHALL be ignored outside RUN.
REQ-023 RUN: if cycle_count equals TIMEOUT and core_done=0, the block SHALL set timeout=1, clear pass, and go to DONE without any readback.
REQ-024 If core_done and the timeout condition occur in the same cycle, core_done SHALL win (go to ISSUE, timeout stays 0).
REQ-025 ISSUE: rd_addr SHALL equal the word index; next state CHECK (one cycle per state, two cycles per word).
REQ-026 CHECK: rd_addr SHALL hold its value; if rd_data != exp_data and no mismatch has been recorded, fail_addr SHALL capture rd_addr and a sticky mismatch flag SHALL be set.
REQ-027 CHECK: if the index is N_CHECK-1, the block SHALL go to DONE; otherwise it SHALL increment the index and go to ISSUE; all N_CHECK words SHALL always be read.
REQ-028 Entering DONE from CHECK, pass SHALL equal NOT(mismatch flag).
REQ-029 DONE: pass, timeout, fail_addr, and cycle_count SHALL hold; start=1 SHALL behave as in IDLE (new run); start in any other state SHALL be ignored.
REQ-030 rd_addr SHALL be 0 in all states other than ISSUE and CHECK.
REQ-031 The index SHALL be 9 bits wide internally, so that N_CHECK=256 terminates without wrap.

Reset
REQ-032 Asynchronous reset=1 SHALL force IDLE and zero every output (core_reset=0, busy=0, finished=0, pass=0, timeout=0, fail_addr=0, rd_addr=0, cycle_count=0), plus the index and mismatch flag.
REQ-033 Reset asserted mid-run (any state) SHALL abort immediately; the first rising edge after release SHALL evaluate IDLE.

Verification
REQ-034 Nominal: start, core_done rises 20 cycles into RUN, memory 0..3 equals exp -> core_reset high 2 cycles, finished=1, pass=1, timeout=0, fail_addr=0, cycle_count=20.
REQ-035 Mismatch: rd_data at addresses 1 and 3 differs from exp -> pass=0, fail_addr=1, all 4 addresses issued (0,1,2,3).
REQ-036 Timeout: TIMEOUT=50, core_done never asserted -> DONE after 50 RUN cycles, timeout=1, pass=0, no rd_addr activity, cycle_count=50.
REQ-037 Tie: core_done rises in the exact cycle cycle_count reaches TIMEOUT -> readback performed, timeout=0.
REQ-038 Reset mid-CHECK, then start again -> all outputs 0 during reset; the second run completes normally with fresh results.
REQ-039 Restart from DONE: a second start after a failed run -> fail_addr and pass cleared at start, and the new results reported independently.

Source files
------------

// File: rtl/run_sequencer.sv
// Test-run sequencer: resets a core, waits for completion or timeout,
// then reads back N_CHECK result words and compares them to expected data.
module run_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int N_CHECK    = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        core_reset,
  input  logic        core_done,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  input  logic [7:0]  exp_data,
  output logic        busy,
  output logic        finished,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  fail_addr,
  output logic [15:0] cycle_count
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [8:0] IDX_LAST = 9'(N_CHECK - 1);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, CRST, RUN, ISSUE, CHECK, DONE
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_rst_cnt;
  logic [8:0]    r_idx;
  logic          r_mis;

  logic [15:0] w_cnt_inc;
  logic        w_tmo;
  logic        w_mis;

  assign w_cnt_inc = (cycle_count == 16'hFFFF) ? cycle_count
                                                : cycle_count + 16'd1;
  assign w_tmo = (w_cnt_inc == TMO);
  assign w_mis = (rd_data != exp_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_idx       <= '0;
      r_mis       <= 1'b0;
      core_reset  <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_addr   <= '0;
      cycle_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_addr   <= '0;
            cycle_count <= '0;
            r_mis       <= 1'b0;
            r_idx       <= '0;
            r_rst_cnt   <= '0;
            core_reset  <= 1'b1;
            busy        <= 1'b1;
            finished    <= 1'b0;
            r_state     <= CRST;
          end
        end
        CRST: begin
          if (r_rst_cnt == RST_LAST) begin
            core_reset <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        RUN: begin
          cycle_count <= w_cnt_inc;
          // completion wins over a timeout landing in the same cycle
          if (core_done) begin
            r_idx   <= '0;
            rd_addr <= '0;
            r_state <= ISSUE;
          end else if (w_tmo) begin
            timeout  <= 1'b1;
            pass     <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b1;
            r_state  <= DONE;
          end
        end
        ISSUE: begin
          r_state <= CHECK;
        end
        CHECK: begin
          if (w_mis && !r_mis) begin
            fail_addr <= rd_addr;
            r_mis     <= 1'b1;
          end
          if (r_idx == IDX_LAST) begin
            pass     <= !(r_mis || w_mis);
            busy     <= 1'b0;
            finished <= 1'b1;
            rd_addr  <= '0;
            r_state  <= DONE;
          end else begin
            r_idx   <= r_idx + 9'd1;
            rd_addr <= 8'(r_idx + 9'd1);
            r_state <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
